// File: rtl/mmcm_ps_sequencer_if.sv
// Request/status bundle between a phase-move requester and mmcm_ps_sequencer.
interface mmcm_ps_sequencer_if #(
    parameter int PS_WIDTH = 12
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_rel;
    logic signed [PS_WIDTH-1:0] req_target;
    logic                       busy;
    logic                       done;
    logic [1:0]                 err;
    logic signed [PS_WIDTH-1:0] cur_pos;

    modport master (
        output req_valid, req_rel, req_target,
        input  req_ready, busy, done, err, cur_pos
    );

    modport slave (
        input  req_valid, req_rel, req_target,
        output req_ready, busy, done, err, cur_pos
    );
endinterface

// File: rtl/mmcm_ps_sequencer.sv
// MMCM fine-phase-shift sequencer: steps PSEN/PSINCDEC one tap at a time toward a clamped target.
// Optional statistics counters are enabled by defining MMCM_PS_SEQ_STATS_EN.
module mmcm_ps_sequencer #(
    parameter int TCQ      = 100,
    parameter int PS_WIDTH = 12,
    parameter int PS_MAX   = 1023,
    parameter int PS_MIN   = -1024,
    parameter int TIMEOUT  = 255,
    parameter int SETTLE   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    mmcm_ps_sequencer_if.slave  req,
    output logic                PSEN,
    output logic                PSINCDEC,
    input  logic                PSDONE
`ifdef MMCM_PS_SEQ_STATS_EN
    ,
    output logic [31:0]         stat_steps,
    output logic [15:0]         stat_timeouts
`endif
);

    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic signed [PS_WIDTH:0] MAX_X   = (PS_WIDTH + 1)'(PS_MAX);
    localparam logic signed [PS_WIDTH:0] MIN_X   = (PS_WIDTH + 1)'(PS_MIN);
    localparam logic [CNT_W-1:0]         TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]         ST_LAST = CNT_W'(SETTLE - 1);

    if (PS_MIN >= 0 || PS_MAX <= 0 || PS_MAX >= 2 ** (PS_WIDTH - 1) ||
        PS_MIN < -(2 ** (PS_WIDTH - 1)) || TIMEOUT < 12 || SETTLE < 0 || TCQ < 0) begin : g_bad_params
        $error("mmcm_ps_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_LOCKWAIT,
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_SETTLE,
        S_FINISH
    } state_t;

    state_t                     state_q, state_d;
    logic signed [PS_WIDTH-1:0] pos_q, pos_d, tgt_q, tgt_d, pos_step;
    logic [1:0]                 err_q, err_d, pend_q, pend_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic                       psen_q, psen_d, inc_q, inc_d;
    logic signed [PS_WIDTH:0]   req_wide, req_sum, req_clamped;
    logic                       req_clip;

    // Relative targets are summed one bit wider so overflow is caught by the clamp.
    always_comb begin
        req_wide    = {req.req_target[PS_WIDTH-1], req.req_target};
        req_sum     = req.req_rel ? ({pos_q[PS_WIDTH-1], pos_q} + req_wide) : req_wide;
        req_clip    = 1'b1;
        req_clamped = req_sum;
        if (req_sum > MAX_X) begin
            req_clamped = MAX_X;
        end else if (req_sum < MIN_X) begin
            req_clamped = MIN_X;
        end else begin
            req_clip = 1'b0;
        end
    end

    assign pos_step = inc_q ? (pos_q + PS_WIDTH'(1)) : (pos_q - PS_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        inc_d   = inc_q;
        done_d  = 1'b0;
        psen_d  = 1'b0;

        unique case (state_q)
            S_LOCKWAIT: begin
                if (pll_lock) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!pll_lock) begin
                    pos_d   = '0;
                    state_d = S_LOCKWAIT;
                end else if (req.req_valid) begin
                    tgt_d   = req_clamped[PS_WIDTH-1:0];
                    err_d   = '0;
                    pend_d  = req_clip ? 2'b01 : 2'b00;
                    busy_d  = 1'b1;
                    state_d = (req_clamped == {pos_q[PS_WIDTH-1], pos_q}) ? S_FINISH : S_STEP;
                end
            end
            S_STEP: begin
                psen_d  = 1'b1;
                inc_d   = tgt_q > pos_q;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (PSDONE) begin
                    pos_d = pos_step;
                    cnt_d = '0;
                    if (pos_step == tgt_q) begin
                        state_d = S_FINISH;
                    end else if (SETTLE == 0) begin
                        // Re-issue from WAIT so a step costs PSDONE latency + 1.
                        psen_d = 1'b1;
                        inc_d  = tgt_q > pos_step;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    pend_d  = 2'b10;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == ST_LAST) begin
                    psen_d  = 1'b1;
                    inc_d   = tgt_q > pos_q;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = pend_q;
                state_d = S_IDLE;
            end
            default: state_d = S_LOCKWAIT;
        endcase

        // Losing lock mid-move overrides everything: the MMCM resets, so phase returns to 0.
        if (!pll_lock && (state_q inside {S_STEP, S_WAIT, S_SETTLE, S_FINISH})) begin
            psen_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 2'b11;
            pos_d   = '0;
            busy_d  = 1'b0;
            state_d = S_LOCKWAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOCKWAIT;
            pos_q   <= '0;
            tgt_q   <= '0;
            err_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            psen_q  <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            psen_q  <= psen_d;
            inc_q   <= inc_d;
        end
    end

    assign req.req_ready = (state_q == S_IDLE) && pll_lock;
    assign req.busy      = busy_q;
    assign req.done      = done_q;
    assign req.err       = err_q;
    assign req.cur_pos   = pos_q;
    assign PSEN          = psen_q;
    assign PSINCDEC      = inc_q;

`ifdef MMCM_PS_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_steps    <= '0;
            stat_timeouts <= '0;
        end else begin
            if (state_q == S_WAIT && PSDONE && pll_lock)
                stat_steps <= stat_steps + 32'd1;
            if (state_q == S_WAIT && !PSDONE && pll_lock && cnt_q == TO_LAST &&
                stat_timeouts != 16'hFFFF)
                stat_timeouts <= stat_timeouts + 16'd1;
        end
    end
`endif

endmodule
